// File: rtl/spi_register_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_register_controller
//  Purpose  : SPI mode-0 slave that turns 16-bit number / 8-bit value frames
//             (with burst auto-increment) into register write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_register_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_MOSI,
    input  logic        i_SPI_CS_n,
    output logic        o_SPI_MISO,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterNumber,
    output logic [7:0]  o_RegisterValue,
    output logic [7:0]  o_WriteCount,
    output logic        o_FrameError
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_NUM_HI = 2'd1;
    localparam logic [1:0] c_S_NUM_LO = 2'd2;
    localparam logic [1:0] c_S_DATA   = 2'd3;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES:0]   r_flush;
    logic                   r_sck_prev;
    logic                   r_cs_prev;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [15:0] r_addr;
    logic [7:0]  r_miso_shift;
    logic        r_strobe;
    logic        r_error;
    logic [15:0] r_number;
    logic [7:0]  r_value;
    logic [7:0]  r_wcount;

    logic        w_sck;
    logic        w_mosi;
    logic        w_cs;
    logic        w_armed;
    logic        w_sck_rise;
    logic        w_sck_fall;
    logic        w_cs_rise;
    logic        w_cs_fall;
    logic        w_active;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic        w_strobe_next;
    logic        w_error_next;
    logic        w_miso;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_flush     <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_SPI_SCK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            r_flush     <= {r_flush[SYNC_STAGES-1:0], 1'b1};
            r_sck_prev  <= w_sck;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sck   = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi  = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs    = r_cs_sync[SYNC_STAGES-1];
    // CS edges are masked until the preset values have flushed out of the
    // synchronizer, so a CS_n held low through reset never opens a frame.
    assign w_armed = r_flush[SYNC_STAGES];

    assign w_sck_rise  = w_sck & ~r_sck_prev;
    assign w_sck_fall  = ~w_sck & r_sck_prev;
    assign w_cs_rise   = w_armed & w_cs & ~r_cs_prev;
    assign w_cs_fall   = w_armed & ~w_cs & r_cs_prev;
    assign w_active    = (r_state != c_S_IDLE);
    assign w_byte_done = w_active & w_sck_rise & (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, w_mosi};

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:   if (w_cs_fall)   w_state_next = c_S_NUM_HI;
            c_S_NUM_HI: if (w_byte_done) w_state_next = c_S_NUM_LO;
            c_S_NUM_LO: if (w_byte_done) w_state_next = c_S_DATA;
            c_S_DATA:   w_state_next = c_S_DATA;
            default:    w_state_next = c_S_IDLE;
        endcase
        if (w_cs_rise) begin
            w_state_next = c_S_IDLE;
        end
    end

    // A byte completing in the same cycle as CS_n rising still counts as clean.
    always_comb begin
        w_strobe_next = w_byte_done & (r_state == c_S_DATA);
        w_error_next  = w_cs_rise & w_active & ~w_byte_done &
                        ((r_state == c_S_NUM_LO) | (r_bit_cnt != 3'd0) | w_sck_rise);
        w_miso        = (r_state == c_S_NUM_HI) & r_miso_shift[7];
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_addr       <= 16'd0;
            r_miso_shift <= 8'd0;
            r_strobe     <= 1'b0;
            r_error      <= 1'b0;
            r_number     <= 16'd0;
            r_value      <= 8'd0;
            r_wcount     <= 8'd0;
        end else begin
            r_strobe <= w_strobe_next;
            r_error  <= w_error_next;

            if (w_cs_rise) begin
                r_bit_cnt <= 3'd0;
            end else if (w_cs_fall && (r_state == c_S_IDLE)) begin
                r_bit_cnt    <= 3'd0;
                r_miso_shift <= r_wcount;
            end else if (w_active && w_sck_rise) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= w_byte[6:0];
            end

            if (w_sck_fall && (r_state == c_S_NUM_HI)) begin
                r_miso_shift <= {r_miso_shift[6:0], 1'b0};
            end

            if (w_byte_done) begin
                case (r_state)
                    c_S_NUM_HI: r_addr[15:8] <= w_byte;
                    c_S_NUM_LO: r_addr[7:0]  <= w_byte;
                    c_S_DATA: begin
                        r_number <= r_addr;
                        r_value  <= w_byte;
                        r_addr   <= r_addr + 16'd1;
                        r_wcount <= r_wcount + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_SPI_MISO            = w_miso;
    assign o_RegisterWriteEnable = r_strobe;
    assign o_RegisterNumber      = r_number;
    assign o_RegisterValue       = r_value;
    assign o_WriteCount          = r_wcount;
    assign o_FrameError          = r_error;

endmodule
`default_nettype wire
